// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, GPIO register map and poller FSM states.
// Imported by the GPIO poller and its timer.
package axi_lite_pkg;

    localparam logic [1:0] RES_OKAY   = 2'b00;
    localparam logic [1:0] RES_SLVERR = 2'b10;

    localparam logic [5:0] GPIO_OFFSET_LED = 6'h08;
    localparam logic [5:0] GPIO_OFFSET_SW  = 6'h0C;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW,
        B
    } poll_state_t;

    // SLVERR and DECERR both carry bit 1
    function automatic logic resp_err(input logic [1:0] resp);
        return (resp & RES_SLVERR) != RES_OKAY;
    endfunction

endpackage

// File: rtl/poll_timer.sv
// Poll interval down-counter: reloads on expiry or on request,
// holds its value while the poller is busy or disabled.
module poll_timer #(
    parameter int POLL_PERIOD = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic reload,
    output logic expire
);

    localparam int W = $clog2(POLL_PERIOD);
    localparam logic [W-1:0] RELOAD_VAL = W'(POLL_PERIOD - 1);

    logic [W-1:0] count_q;

    assign expire = (count_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RELOAD_VAL;
        end else if (reload || (!hold && expire)) begin
            count_q <= RELOAD_VAL;
        end else if (!hold) begin
            count_q <= count_q - W'(1);
        end
    end

endmodule

// File: rtl/axi_lite_gpio_poller.sv
// AXI4-Lite master mirroring the GPIO switch register onto the LED register,
// with saturating error and wrapping poll counters for debug.
module axi_lite_gpio_poller
    import axi_lite_pkg::*;
#(
    parameter int                    POLL_PERIOD     = 100000,
    parameter int                    ADDR_WIDTH      = 6,
    parameter int                    DATA_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] OFFSET_SW       = ADDR_WIDTH'(GPIO_OFFSET_SW),
    parameter logic [ADDR_WIDTH-1:0] OFFSET_LED      = ADDR_WIDTH'(GPIO_OFFSET_LED),
    parameter bit                    WRITE_ON_CHANGE = 1'b1
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_aresetn,
    input  logic                    enable,
    input  logic                    poll_now,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic                    busy,
    output logic [3:0]              last_sw,
    output logic [7:0]              err_count,
    output logic [15:0]             poll_count
);

    poll_state_t state_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        wrote_ok_q;
    logic        expire;
    logic        idle;
    logic        start;
    logic        aw_fin;
    logic        w_fin;
    logic [7:0]  err_inc;
    logic        unused_rdata;

    assign idle  = (state_q == IDLE);
    assign busy  = !idle;
    assign start = idle && enable && (expire || poll_now);

    assign aw_fin  = aw_done_q || (m_axi_awvalid && m_axi_awready);
    assign w_fin   = w_done_q || (m_axi_wvalid && m_axi_wready);
    assign err_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    assign m_axi_araddr = OFFSET_SW;
    assign m_axi_awaddr = OFFSET_LED;
    assign m_axi_arprot = 3'b000;
    assign m_axi_awprot = 3'b000;
    assign m_axi_wstrb  = '1;

    // only the four switch bits are meaningful
    assign unused_rdata = ^m_axi_rdata[DATA_WIDTH-1:4];

    poll_timer #(
        .POLL_PERIOD(POLL_PERIOD)
    ) u_timer (
        .clk   (m_axi_aclk),
        .rst_n (m_axi_aresetn),
        .hold  (!(enable && idle)),
        .reload(start),
        .expire(expire)
    );

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q       <= IDLE;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_wdata   <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            wrote_ok_q    <= 1'b0;
            last_sw       <= 4'h0;
            err_count     <= 8'h00;
            poll_count    <= 16'h0000;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= AR;
                        m_axi_arvalid <= 1'b1;
                    end
                end
                AR: begin
                    if (m_axi_arready) begin
                        state_q       <= R;
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                    end
                end
                R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        if (resp_err(m_axi_rresp)) begin
                            err_count  <= err_inc;
                            poll_count <= poll_count + 16'd1;
                            state_q    <= IDLE;
                        end else if (WRITE_ON_CHANGE && wrote_ok_q &&
                                     m_axi_rdata[3:0] == last_sw) begin
                            poll_count <= poll_count + 16'd1;
                            state_q    <= IDLE;
                        end else begin
                            last_sw       <= m_axi_rdata[3:0];
                            m_axi_wdata   <= DATA_WIDTH'(m_axi_rdata[3:0]);
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done_q     <= 1'b0;
                            w_done_q      <= 1'b0;
                            state_q       <= AW;
                        end
                    end
                end
                AW: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done_q     <= 1'b1;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        w_done_q     <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        m_axi_bready <= 1'b1;
                        state_q      <= B;
                    end
                end
                B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        poll_count   <= poll_count + 16'd1;
                        // a failed write forces a rewrite on the next poll
                        if (resp_err(m_axi_bresp)) begin
                            err_count  <= err_inc;
                            wrote_ok_q <= 1'b0;
                        end else begin
                            wrote_ok_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_gpio_poller.sv
// Bench for axi_lite_gpio_poller: reactive GPIO slave, handshake monitor
// and a poll-level reference model of the switch-to-LED mirroring.
module tb_axi_lite_gpio_poller;

    localparam int AWD = 6;
    localparam int DW  = 32;
    localparam int PER = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           poll_now = 1'b0;
    logic [AWD-1:0] awaddr, araddr;
    logic [2:0]     awprot, arprot;
    logic           awvalid, wvalid, bready, arvalid, rready;
    logic           awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [DW-1:0]  wdata;
    logic [3:0]     wstrb;
    logic [1:0]     bresp = 0, rresp = 0;
    logic [DW-1:0]  rdata = 0;
    logic           busy;
    logic [3:0]     last_sw;
    logic [7:0]     err_count;
    logic [15:0]    poll_count;

    always #5 clk = ~clk;

    axi_lite_gpio_poller #(
        .POLL_PERIOD(PER)
    ) dut (
        .m_axi_aclk   (clk),
        .m_axi_aresetn(rst_n),
        .enable       (enable),
        .poll_now     (poll_now),
        .m_axi_awaddr (awaddr),
        .m_axi_awprot (awprot),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata  (wdata),
        .m_axi_wstrb  (wstrb),
        .m_axi_wvalid (wvalid),
        .m_axi_wready (wready),
        .m_axi_bresp  (bresp),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (bready),
        .m_axi_araddr (araddr),
        .m_axi_arprot (arprot),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp),
        .m_axi_rvalid (rvalid),
        .m_axi_rready (rready),
        .busy         (busy),
        .last_sw      (last_sw),
        .err_count    (err_count),
        .poll_count   (poll_count)
    );

    int errors = 0;
    int checks = 0;

    // slave knobs
    logic [3:0] sw_val = 4'h0;
    bit         rd_err = 0, wr_err = 0;
    int         aw_delay = 0, w_delay = 0;
    int         aw_wait = 0, w_wait = 0;

    // monitor state
    int         ar_hs = 0, aw_hs = 0, w_hs = 0;
    int         aw_cyc = 0, w_cyc = 0, last_aw_cycles = 0, last_w_cycles = 0;
    bit         aw_done_m = 0, w_done_m = 0;
    bit         bad_araddr = 0, bad_awaddr = 0, split = 0, b_early = 0, w_unstable = 0;
    logic [31:0] last_wdata = 0, prev_wdata = 0;
    logic [3:0] last_wstrb = 0;
    logic [3:0] led = 0;

    // reference model
    logic [3:0]  m_last_sw = 0;
    bit          m_ok = 0;
    int          m_err = 0;
    logic [15:0] m_polls = 0;
    int          m_writes = 0;
    logic [3:0]  m_led = 0;

    // reactive zero-wait GPIO slave with optional AW/W ready delays
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                aw_wait = 0; w_wait = 0;
            end else begin
                arready = arvalid;
                rvalid  = rready;
                rdata   = {28'($urandom()), sw_val};
                rresp   = rd_err ? 2'b10 : 2'b00;
                if (awvalid) begin
                    if (aw_wait >= aw_delay) awready = 1;
                    else begin awready = 0; aw_wait++; end
                end else begin
                    awready = 0; aw_wait = 0;
                end
                if (wvalid) begin
                    if (w_wait >= w_delay) wready = 1;
                    else begin wready = 0; w_wait++; end
                end else begin
                    wready = 0; w_wait = 0;
                end
                bvalid = bready;
                bresp  = wr_err ? 2'b10 : 2'b00;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (arvalid && araddr != 6'h0C) bad_araddr <= 1;
            if (awvalid && awaddr != 6'h08) bad_awaddr <= 1;
            if (arvalid && arready) begin
                ar_hs <= ar_hs + 1;
                aw_done_m <= 0; w_done_m <= 0; aw_cyc <= 0; w_cyc <= 0;
            end
            if (awvalid) aw_cyc <= aw_cyc + 1;
            if (wvalid) begin
                w_cyc <= w_cyc + 1;
                prev_wdata <= wdata;
                if (w_cyc != 0 && wdata != prev_wdata) w_unstable <= 1;
            end
            if (awvalid && awready) begin
                aw_done_m <= 1; aw_hs <= aw_hs + 1; last_aw_cycles <= aw_cyc + 1;
            end
            if (wvalid && wready) begin
                w_done_m <= 1; w_hs <= w_hs + 1; last_w_cycles <= w_cyc + 1;
                last_wdata <= wdata; last_wstrb <= wstrb;
            end
            if (awvalid != wvalid && !aw_done_m && !w_done_m) split <= 1;
            if (bready && !(aw_done_m && w_done_m)) b_early <= 1;
            if (bvalid && bready && bresp == 2'b00) led <= last_wdata[3:0];
        end
    end

    task automatic model_reset();
        m_last_sw = 0; m_ok = 0; m_err = 0; m_polls = 0;
    endtask

    task automatic model_poll(input logic [3:0] sw, input bit re, input bit be,
                              input int daw, input int dw, output int exp_busy);
        m_polls = m_polls + 16'd1;
        if (re) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            exp_busy = 2;
            return;
        end
        if (sw == m_last_sw && m_ok) begin
            exp_busy = 2;
            return;
        end
        m_last_sw = sw;
        m_writes++;
        exp_busy = 4 + ((daw > dw) ? daw : dw);
        if (be) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            m_ok = 0;
        end else begin
            m_ok = 1;
            m_led = sw;
        end
    endtask

    task automatic do_poll(input logic [3:0] sw, input bit re, input bit be,
                           input int daw, input int dw, output int cyc);
        sw_val = sw; rd_err = re; wr_err = be; aw_delay = daw; w_delay = dw;
        @(negedge clk); enable = 1; poll_now = 1;
        @(negedge clk); enable = 0; poll_now = 0;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL poll_timeout: busy still %0b after %0d cycles", busy, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 0; poll_now = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b want 00000",
                     {arvalid, rready, awvalid, wvalid, bready});
        end
        checks++;
        if ({busy, last_sw, err_count, poll_count} !== 29'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b sw=%h err=%0d polls=%0d want all 0",
                     busy, last_sw, err_count, poll_count);
        end
        rst_n = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_disabled: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic_write();
        int cyc, exp;
        do_poll(4'hA, 0, 0, 0, 0, cyc);
        model_poll(4'hA, 0, 0, 0, 0, exp);
        checks++;
        if (cyc !== exp) begin
            errors++; $display("FAIL basic_latency: got %0d want %0d", cyc, exp);
        end
        checks++;
        if (last_wdata !== 32'h0000000A || last_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL basic_wdata: got %h/%h want 0000000a/f", last_wdata, last_wstrb);
        end
        checks++;
        if (led !== 4'hA || last_sw !== 4'hA) begin
            errors++; $display("FAIL basic_led: led=%h last_sw=%h want a", led, last_sw);
        end
        checks++;
        if (poll_count !== 16'd1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL basic_counts: polls=%0d err=%0d want 1/0", poll_count, err_count);
        end
        checks++;
        if (bad_araddr || bad_awaddr || awprot !== 3'b0 || arprot !== 3'b0) begin
            errors++;
            $display("FAIL basic_addr: bad_ar=%b bad_aw=%b want 0/0", bad_araddr, bad_awaddr);
        end
    endtask

    task automatic test_write_on_change();
        int cyc, exp;
        int w0 = w_hs;
        for (int i = 0; i < 3; i++) begin
            do_poll(4'hA, 0, 0, 0, 0, cyc);
            model_poll(4'hA, 0, 0, 0, 0, exp);
            checks++;
            if (cyc !== exp) begin
                errors++; $display("FAIL woc_skip_latency: got %0d want %0d", cyc, exp);
            end
        end
        checks++;
        if (w_hs - w0 !== 0 || poll_count !== 16'd4) begin
            errors++;
            $display("FAIL woc_skip: writes=%0d polls=%0d want 0/4", w_hs - w0, poll_count);
        end
        do_poll(4'h5, 0, 0, 0, 0, cyc);
        model_poll(4'h5, 0, 0, 0, 0, exp);
        checks++;
        if (w_hs - w0 !== 1 || last_wdata !== 32'h5 || led !== 4'h5) begin
            errors++;
            $display("FAIL woc_change: writes=%0d wdata=%h led=%h want 1/5/5",
                     w_hs - w0, last_wdata, led);
        end
    endtask

    task automatic test_read_error();
        int cyc, exp;
        int w0 = w_hs;
        do_poll(4'h3, 1, 0, 0, 0, cyc);
        model_poll(4'h3, 1, 0, 0, 0, exp);
        checks++;
        if (w_hs - w0 !== 0 || err_count !== 8'd1 || last_sw !== m_last_sw) begin
            errors++;
            $display("FAIL read_error: writes=%0d err=%0d sw=%h want 0/1/%h",
                     w_hs - w0, err_count, last_sw, m_last_sw);
        end
    endtask

    task automatic test_delayed_handshake();
        int cyc, exp;
        do_poll(4'hC, 0, 0, 3, 0, cyc);
        model_poll(4'hC, 0, 0, 3, 0, exp);
        checks++;
        if (last_aw_cycles !== 4 || last_w_cycles !== 1) begin
            errors++;
            $display("FAIL delayed_valids: aw=%0d w=%0d want 4/1", last_aw_cycles, last_w_cycles);
        end
        checks++;
        if (cyc !== exp) begin
            errors++; $display("FAIL delayed_latency: got %0d want %0d", cyc, exp);
        end
        checks++;
        if (split || b_early || bad_awaddr || w_unstable) begin
            errors++;
            $display("FAIL delayed_protocol: split=%b b_early=%b aw=%b wd=%b want 0",
                     split, b_early, bad_awaddr, w_unstable);
        end
    endtask

    task automatic test_random();
        int cyc, exp, daw, dw;
        logic [3:0] sw;
        bit re, be;
        for (int i = 0; i < 40; i++) begin
            sw  = 4'($urandom_range(0, 3));
            re  = ($urandom_range(0, 5) == 0);
            be  = ($urandom_range(0, 5) == 0);
            daw = $urandom_range(0, 3);
            dw  = $urandom_range(0, 3);
            do_poll(sw, re, be, daw, dw, cyc);
            model_poll(sw, re, be, daw, dw, exp);
            checks++;
            if (cyc !== exp) begin
                errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, cyc, exp);
            end
            checks++;
            if (last_sw !== m_last_sw || err_count !== 8'(m_err) || poll_count !== m_polls) begin
                errors++;
                $display("FAIL rand_state[%0d]: sw=%h err=%0d polls=%0d want %h/%0d/%0d",
                         i, last_sw, err_count, poll_count, m_last_sw, m_err, m_polls);
            end
            checks++;
            if (w_hs !== m_writes || led !== m_led) begin
                errors++;
                $display("FAIL rand_writes[%0d]: writes=%0d led=%h want %0d/%h",
                         i, w_hs, led, m_writes, m_led);
            end
        end
        checks++;
        if (split || b_early || bad_araddr || bad_awaddr || w_unstable) begin
            errors++;
            $display("FAIL rand_protocol: split=%b b_early=%b want 0/0", split, b_early);
        end
    endtask

    task automatic test_err_saturate();
        int cyc, exp;
        for (int i = 0; i < 300; i++) begin
            do_poll(4'h1, 1, 0, 0, 0, cyc);
            model_poll(4'h1, 1, 0, 0, 0, exp);
        end
        checks++;
        if (err_count !== 8'hFF || poll_count !== m_polls) begin
            errors++;
            $display("FAIL err_saturate: err=%0d polls=%0d want 255/%0d",
                     err_count, poll_count, m_polls);
        end
    endtask

    task automatic test_timer_and_poll_now();
        int t, ar0, cyc, exp;
        sw_val = 4'h7; rd_err = 0; wr_err = 0; aw_delay = 0; w_delay = 0;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1; enable = 1;
        model_reset();
        ar0 = ar_hs;
        repeat (15) @(negedge clk);
        checks++;
        if (arvalid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL timer_early: arvalid=%b busy=%b want 0/0", arvalid, busy);
        end
        poll_now = 1;
        @(negedge clk); poll_now = 0;
        checks++;
        if (arvalid !== 1'b1) begin
            errors++; $display("FAIL timer_expiry: arvalid=%b want 1", arvalid);
        end
        t = 0;
        do begin
            @(negedge clk); t++;
        end while (!arvalid && t < 100);
        checks++;
        if (t !== 20 || ar_hs - ar0 !== 1) begin
            errors++;
            $display("FAIL timer_period: interval=%0d ars=%0d want 20/1", t, ar_hs - ar0);
        end
        enable = 0;
        cyc = 0;
        while (busy && cyc < 100) begin cyc++; @(negedge clk); end
        model_poll(4'h7, 0, 0, 0, 0, exp);
        model_poll(4'h7, 0, 0, 0, 0, exp);
        checks++;
        if (ar_hs - ar0 !== 2 || poll_count !== m_polls || busy !== 1'b0) begin
            errors++;
            $display("FAIL timer_polls: ars=%0d polls=%0d want 2/%0d", ar_hs - ar0, poll_count, m_polls);
        end
        ar0 = ar_hs;
        @(negedge clk); enable = 1; poll_now = 1;
        @(negedge clk); poll_now = 0;
        @(negedge clk); poll_now = 1;
        @(negedge clk); poll_now = 0; enable = 0;
        repeat (5) @(negedge clk);
        model_poll(4'h7, 0, 0, 0, 0, exp);
        checks++;
        if (ar_hs - ar0 !== 1 || poll_count !== m_polls) begin
            errors++;
            $display("FAIL poll_now_busy: ars=%0d polls=%0d want 1/%0d", ar_hs - ar0, poll_count, m_polls);
        end
    endtask

    task automatic test_reset_mid_aw();
        int t;
        sw_val = 4'h9; rd_err = 0; wr_err = 0; aw_delay = 10; w_delay = 10;
        @(negedge clk); enable = 1; poll_now = 1;
        @(negedge clk); enable = 0; poll_now = 0;
        t = 0;
        while (!awvalid && t < 20) begin t++; @(negedge clk); end
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            errors++; $display("FAIL mid_aw_reach: aw=%b w=%b want 1/1", awvalid, wvalid);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: aw=%b w=%b busy=%b want 0/0/0", awvalid, wvalid, busy);
        end
        @(negedge clk); rst_n = 1;
        model_reset();
        @(negedge clk);
        checks++;
        if (poll_count !== m_polls || err_count !== 8'(m_err) || last_sw !== m_last_sw ||
            busy !== 1'b0 || arvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: polls=%0d err=%0d sw=%h busy=%b want 0/0/0/0",
                     poll_count, err_count, last_sw, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_write_on_change();
        test_read_error();
        test_delayed_handshake();
        test_random();
        test_err_saturate();
        test_timer_and_poll_now();
        test_reset_mid_aw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
